// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULT/DIV sequencer that borrows the shared EX-stage ALU; results land in HI/LO.
// Optional feature macro: MULDIV_DIV_EN (DIV path, DCMP/DSUB/DZERO states, div0_out). Undefined -> MULT only.
module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             div0_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             alu_sel_out,
  output logic [WIDTH-1:0] alu_a_out,
  output logic [WIDTH-1:0] alu_b_out,
  output logic [3:0]       alu_ctrl_out,
  input  logic [WIDTH-1:0] alu_result_in,
  output logic [2:0]       state_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

`ifdef MULDIV_DIV_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DCMP, S_DSUB, S_DZERO, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mul_sum;
  logic             mul_carry;
  logic [WIDTH:0]   sh;

  // Multiplier step: the ALU adds, the carry-out is recovered from unsigned wrap.
  assign mul_sum   = lo[0] ? alu_result_in : hi;
  assign mul_carry = lo[0] & (alu_result_in < hi);
  assign sh        = {hi, lo[WIDTH-1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] divisor;
  logic             qbit;
  logic             div0;
  assign div0_out = div0;
`else
  logic unused_op;
  assign unused_op = op_in;
  assign div0_out  = 1'b0;
`endif

  assign state_out = state;
  assign busy_out  = (state != S_IDLE);
  assign done_out  = (state == S_DONE);
  assign hi_out    = hi;
  assign lo_out    = lo;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    alu_sel_out  = 1'b0;
    alu_a_out    = '0;
    alu_b_out    = '0;
    alu_ctrl_out = CTRL_ADD;
    case (state)
      S_IDLE: begin
        if (start_in) begin
`ifdef MULDIV_DIV_EN
          if (op_in) state_nxt = (b_in == '0) ? S_DZERO : S_DCMP;
          else       state_nxt = S_MUL;
`else
          state_nxt = S_MUL;
`endif
        end
      end
      S_MUL: begin
        alu_sel_out = 1'b1;
        alu_a_out   = hi;
        alu_b_out   = mcand;
        if (count == '0) state_nxt = S_DONE;
      end
`ifdef MULDIV_DIV_EN
      S_DCMP: begin
        alu_sel_out  = 1'b1;
        alu_a_out    = sh[WIDTH-1:0];
        alu_b_out    = divisor;
        alu_ctrl_out = CTRL_SLT;
        state_nxt    = S_DSUB;
      end
      S_DSUB: begin
        alu_sel_out  = 1'b1;
        alu_a_out    = sh[WIDTH-1:0];
        alu_b_out    = divisor;
        alu_ctrl_out = CTRL_SUB;
        state_nxt    = (count == '0) ? S_DONE : S_DCMP;
      end
      S_DZERO: state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // hi/lo double as the working registers: product halves for MULT, remainder/quotient for DIV.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      count <= '0;
`ifdef MULDIV_DIV_EN
      divisor <= '0;
      qbit    <= 1'b0;
      div0    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            mcand <= a_in;
            count <= CW'(WIDTH - 1);
            hi    <= '0;
`ifdef MULDIV_DIV_EN
            divisor <= b_in;
            div0    <= 1'b0;
            lo      <= op_in ? a_in : b_in;
`else
            lo      <= b_in;
`endif
          end
        end
        S_MUL: begin
          {hi, lo} <= {mul_carry, mul_sum, lo[WIDTH-1:1]};
          count    <= count - 1'b1;
        end
`ifdef MULDIV_DIV_EN
        S_DCMP: qbit <= sh[WIDTH] | ~alu_result_in[0];
        S_DSUB: begin
          hi    <= qbit ? alu_result_in : sh[WIDTH-1:0];
          lo    <= {lo[WIDTH-2:0], qbit};
          count <= count - 1'b1;
        end
        S_DZERO: begin
          hi   <= lo;
          lo   <= '1;
          div0 <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq (WIDTH=16) with a behavioural ALU on alu_result_in.
// Covers the DIV path too when built with MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div0, alu_sel;
  logic [W-1:0] hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic [2:0]   state;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];
  int lat, sel_first, sel_last, sel_cnt;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .op_in(op),
    .a_in(a), .b_in(b), .busy_out(busy), .done_out(done), .div0_out(div0),
    .hi_out(hi), .lo_out(lo), .alu_sel_out(alu_sel), .alu_a_out(alu_a),
    .alu_b_out(alu_b), .alu_ctrl_out(alu_ctrl), .alu_result_in(alu_result),
    .state_out(state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Shared ALU as seen by EX (unsigned set-less-than)
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {{(W-1){1'b0}}, (alu_a < alu_b)};
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input string tag);
    check(tag, {hi, lo}, exp_q.pop_front());
  endtask

  // Driver: start accepted at the posedge ending cycle 0; returns in the DONE cycle (negedge).
  task automatic run(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv, input int pulse_at,
                     output int lat_o, output int first_o, output int last_o, output int cnt_o);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 16'hFFFF)); b = W'($urandom_range(0, 16'hFFFF));
    cyc = 1; first_o = -1; last_o = -1; cnt_o = 0;
    while (!done && cyc < 200) begin
      if (alu_sel) begin
        if (first_o < 0) first_o = cyc;
        last_o = cyc;
        cnt_o++;
      end
      start = (cyc == pulse_at);
      op = ~o;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    lat_o = done ? cyc : -1;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_busy_done_div0_sel", {busy, done, div0, alu_sel}, '0);
    check("rst_hilo", {hi, lo}, '0);
    check("rst_alu_ab", {alu_a, alu_b}, '0);
    check("rst_alu_ctrl", alu_ctrl, 4'b0010);
    @(negedge clk); rst_n = 1'b1;

    // MULT 3*5
    exp_q.push_back(32'h0000_000F);
    run(1'b0, 16'h0003, 16'h0005, -1, lat, sel_first, sel_last, sel_cnt);
    check("mul3x5_latency", lat, 17);
    check_result("mul3x5_hilo");
    check("mul3x5_sel_window", {sel_first[15:0], sel_last[15:0]}, {16'd1, 16'd16});
    check("mul3x5_sel_count", sel_cnt, 16);
    check("mul3x5_done_busy_sel", {done, busy, alu_sel}, 3'b110);
    check("mul_div0_clear", div0, 1'b0);
    // start on the DONE cycle must be ignored
    start = 1'b1; a = 16'h0007; b = 16'h0007; op = 1'b0;
    @(negedge clk); start = 1'b0;
    check("after_done_idle", {busy, done, alu_sel, alu_ctrl}, {3'b000, 4'b0010});
    @(negedge clk);
    check("done_start_ignored", busy, 1'b0);
    check("hold_hilo", {hi, lo}, 32'h0000_000F);

    // MULT FFFF*FFFF (carry path)
    exp_q.push_back(32'hFFFE_0001);
    run(1'b0, 16'hFFFF, 16'hFFFF, -1, lat, sel_first, sel_last, sel_cnt);
    check("mulffff_latency", lat, 17);
    check_result("mulffff_hilo");

    // MULT 1234h*5678h
    exp_q.push_back(32'h0626_0060);
    run(1'b0, 16'h1234, 16'h5678, -1, lat, sel_first, sel_last, sel_cnt);
    check_result("mul1234_hilo");

    // start pulsed mid-MULT
    exp_q.push_back(32'h0000_FFFF);
    run(1'b0, 16'h00FF, 16'h0101, 5, lat, sel_first, sel_last, sel_cnt);
    check("mulpulse_latency", lat, 17);
    check_result("mulpulse_hilo");

`ifdef MULDIV_DIV_EN
    // DIV 100/7
    exp_q.push_back(32'h0002_000E);
    run(1'b1, 16'd100, 16'd7, -1, lat, sel_first, sel_last, sel_cnt);
    check("div100_latency", lat, 33);
    check_result("div100_hilo");
    check("div100_div0", div0, 1'b0);
    check("div100_sel_window", {sel_first[15:0], sel_last[15:0]}, {16'd1, 16'd32});

    // DIV FFFF/1
    exp_q.push_back(32'h0000_FFFF);
    run(1'b1, 16'hFFFF, 16'h0001, -1, lat, sel_first, sel_last, sel_cnt);
    check_result("divffff_hilo");

    // DIV 1234/0
    exp_q.push_back(32'h04D2_FFFF);
    run(1'b1, 16'd1234, 16'd0, -1, lat, sel_first, sel_last, sel_cnt);
    check("div0_latency", lat, 2);
    check_result("div0_hilo");
    check("div0_flag", div0, 1'b1);
    check("div0_sel_never", sel_cnt, 0);
    repeat (3) @(negedge clk);
    check("div0_flag_held", {div0, hi, lo}, {1'b1, 32'h04D2_FFFF});

    // reset mid-DIV
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 16'd100; b = 16'd7;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("middiv_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_middiv", {busy, alu_sel, div0, hi, lo}, '0);
    @(negedge clk); rst_n = 1'b1;
`else
    // op=1 behaves as MULT without the DIV build
    exp_q.push_back(32'h0000_02BC);
    run(1'b1, 16'd100, 16'd7, -1, lat, sel_first, sel_last, sel_cnt);
    check("nodiv_latency", lat, 17);
    check_result("nodiv_hilo");
    check("nodiv_div0", div0, 1'b0);

    // reset mid-MULT
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'hFFFF;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("midmul_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_midmul", {busy, alu_sel, div0, hi, lo}, '0);
    @(negedge clk); rst_n = 1'b1;
`endif
    @(negedge clk);
    check("post_reset_idle", {busy, done, alu_ctrl}, {2'b00, 4'b0010});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
